rc_tdc_multi: RTL and testbench

- Multi-channel, parametrised RC charge-time measurement engine.
- Per measurement it discharges the selected external RC network, drives its step output high, and counts clk cycles until the threshold input returns high.
- Averages 2^AVG_LOG2 such samples and converts the mean count to a resistance code by sequential division with a fixed calibration divisor (C·ln2 in clk counts).
- Sits between the chip pads (step_set/step_in per channel) and the user output bus; replaces the single-channel free-running timer.

---
 rtl/rc_tdc_multi.sv | 217 +++++++++++++++++++++
 tb/tb_rc_tdc_multi.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc_tdc_multi.sv
// rc_tdc_multi: multi-channel RC charge-time measurement engine.
// Discharges the selected RC network, charges it through step_set, counts
// cycles until the synchronized threshold input rises, averages
// 2^AVG_LOG2 samples and divides the mean by a calibration divisor.
module rc_tdc_multi #(
    parameter int               NCH          = 4,
    parameter int               CNT_W        = 24,
    parameter int               OUT_W        = 8,
    parameter int               AVG_LOG2     = 2,
    parameter int               DISCH_CYCLES = 1024,
    parameter logic [CNT_W-1:0] TIMEOUT      = '1,
    parameter logic [CNT_W-1:0] DIVISOR      = CNT_W'(6900),
    parameter int               SEL_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [SEL_W-1:0] ch_sel,
    input  logic [NCH-1:0]   step_in,
    output logic [NCH-1:0]   step_set,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] result,
    output logic [CNT_W-1:0] raw_count,
    output logic             sat,
    output logic [1:0]       err
);

    localparam int ACC_W = CNT_W + AVG_LOG2;
    localparam int SMP_W = AVG_LOG2 + 1;
    localparam int DC_W  = $clog2(DISCH_CYCLES + 1);
    localparam int BIT_W = $clog2(CNT_W + 1);

    localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(DISCH_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CNT_W - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = TIMEOUT - CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISCH,
        S_CHARGE,
        S_ACCUM,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [NCH-1:0]   sync1_reg, sin_reg;
    logic [NCH-1:0]   sel_oh;
    logic [SEL_W-1:0] ch_reg;
    logic [DC_W-1:0]  dc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [ACC_W-1:0] acc_reg;
    logic [SMP_W-1:0] smp_reg;
    logic [CNT_W-1:0] avg_reg, quo_reg, rem_reg;
    logic [BIT_W-1:0] bit_reg;
    logic             done_reg, sat_reg;
    logic [OUT_W-1:0] result_reg;
    logic [CNT_W-1:0] raw_reg;
    logic [1:0]       err_reg;

    logic             accept, charging, sin_ch;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] avg_next;
    logic [CNT_W:0]   rem_sh;
    logic             rem_ge, q_over;
    logic [CNT_W-1:0] rem_step, quo_step;

    assign accept   = (state_reg == S_IDLE) && start && (int'(ch_sel) < NCH);
    assign charging = (state_reg == S_CHARGE);

    // Channel decode: one-hot select drives the excitation and picks the threshold bit
    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign sel_oh[gi]   = (ch_reg == SEL_W'(gi));
            assign step_set[gi] = charging && sel_oh[gi];
        end
    endgenerate

    assign sin_ch = |(sin_reg & sel_oh);

    // Accumulation and the truncating mean
    assign acc_sum  = acc_reg + ACC_W'(cnt_reg);
    assign avg_next = CNT_W'(acc_sum >> AVG_LOG2);

    // One restoring-division step: quotient bits shift in from the bottom of quo_reg
    assign rem_sh   = {rem_reg, quo_reg[CNT_W-1]};
    assign rem_ge   = (rem_sh >= {1'b0, DIVISOR});
    assign rem_step = rem_ge ? CNT_W'(rem_sh - {1'b0, DIVISOR}) : rem_sh[CNT_W-1:0];
    assign quo_step = {quo_reg[CNT_W-2:0], rem_ge};
    assign q_over   = ((quo_step >> OUT_W) != '0);

    assign busy      = (state_reg != S_IDLE);
    assign done      = done_reg;
    assign result    = result_reg;
    assign raw_count = raw_reg;
    assign sat       = sat_reg;
    assign err       = err_reg;

    // Two-flop synchronizer for the asynchronous comparator inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '0;
            sin_reg   <= '0;
        end else begin
            sync1_reg <= step_in;
            sin_reg   <= sync1_reg;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = S_DISCH;
            S_DISCH:  if (dc_reg == DC_LAST) state_next = sin_ch ? S_DONE : S_CHARGE;
            S_CHARGE: begin
                if (sin_ch)                  state_next = S_ACCUM;
                else if (cnt_reg == TO_LAST) state_next = S_DONE;
            end
            S_ACCUM:  state_next = (smp_reg == SMP_LAST) ? S_DIVIDE : S_DISCH;
            S_DIVIDE: if (bit_reg == BIT_LAST) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath: counters, accumulator, divider and the result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_reg     <= '0;
            dc_reg     <= '0;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            smp_reg    <= '0;
            avg_reg    <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            bit_reg    <= '0;
            done_reg   <= 1'b0;
            sat_reg    <= 1'b0;
            result_reg <= '0;
            raw_reg    <= '0;
            err_reg    <= 2'b00;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        ch_reg  <= ch_sel;
                        dc_reg  <= '0;
                        acc_reg <= '0;
                        smp_reg <= '0;
                    end
                end
                S_DISCH: begin
                    dc_reg  <= dc_reg + DC_W'(1);
                    cnt_reg <= '0;
                    // Comparator already high after a full discharge: input stuck
                    if ((dc_reg == DC_LAST) && sin_ch) begin
                        done_reg   <= 1'b1;
                        result_reg <= '0;
                        raw_reg    <= '0;
                        sat_reg    <= 1'b0;
                        err_reg    <= 2'b10;
                    end
                end
                S_CHARGE: begin
                    if (!sin_ch) begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                        if (cnt_reg == TO_LAST) begin
                            done_reg   <= 1'b1;
                            result_reg <= '1;
                            raw_reg    <= TIMEOUT;
                            sat_reg    <= 1'b0;
                            err_reg    <= 2'b01;
                        end
                    end
                end
                S_ACCUM: begin
                    acc_reg <= acc_sum;
                    smp_reg <= smp_reg + SMP_W'(1);
                    dc_reg  <= '0;
                    if (smp_reg == SMP_LAST) begin
                        avg_reg <= avg_next;
                        quo_reg <= avg_next;
                        rem_reg <= '0;
                        bit_reg <= '0;
                    end
                end
                S_DIVIDE: begin
                    quo_reg <= quo_step;
                    rem_reg <= rem_step;
                    bit_reg <= bit_reg + BIT_W'(1);
                    if (bit_reg == BIT_LAST) begin
                        done_reg   <= 1'b1;
                        raw_reg    <= avg_reg;
                        sat_reg    <= q_over;
                        result_reg <= q_over ? '1 : quo_step[OUT_W-1:0];
                        err_reg    <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc_tdc_multi.sv
// Testbench for rc_tdc_multi: two instances (1 sample and 4 samples per
// measurement) driven by an RC-network stand-in, checked every cycle
// against an arithmetic reference model of the measurement.
module tb_rc_tdc_multi;
    localparam int NCH     = 4;
    localparam int CNT_W   = 16;
    localparam int OUT_W   = 8;
    localparam int DISCH   = 8;
    localparam int TIMEOUT = 4000;
    localparam int DIVISOR = 10;
    localparam int SEL_W   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             start     [2];
    logic [SEL_W-1:0] ch_sel    [2];
    logic [NCH-1:0]   step_in   [2];
    logic [NCH-1:0]   step_set  [2];
    logic             busy      [2];
    logic             done      [2];
    logic [OUT_W-1:0] result    [2];
    logic [CNT_W-1:0] raw_count [2];
    logic             sat       [2];
    logic [1:0]       err       [2];

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    rc_tdc_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .OUT_W(OUT_W), .AVG_LOG2(0), .DISCH_CYCLES(DISCH),
        .TIMEOUT(16'd4000), .DIVISOR(16'd10), .SEL_W(SEL_W)
    ) dut0 (
        .clk(clk), .reset(reset), .start(start[0]), .ch_sel(ch_sel[0]),
        .step_in(step_in[0]), .step_set(step_set[0]), .busy(busy[0]), .done(done[0]),
        .result(result[0]), .raw_count(raw_count[0]), .sat(sat[0]), .err(err[0])
    );

    rc_tdc_multi #(
        .NCH(NCH), .CNT_W(CNT_W), .OUT_W(OUT_W), .AVG_LOG2(2), .DISCH_CYCLES(DISCH),
        .TIMEOUT(16'd4000), .DIVISOR(16'd10), .SEL_W(SEL_W)
    ) dut2 (
        .clk(clk), .reset(reset), .start(start[1]), .ch_sel(ch_sel[1]),
        .step_in(step_in[1]), .step_set(step_set[1]), .busy(busy[1]), .done(done[1]),
        .result(result[1]), .raw_count(raw_count[1]), .sat(sat[1]), .err(err[1])
    );

    // Reference model state per instance: expected transaction and held outputs
    bit         act   [2];
    longint     m_e0  [2];
    longint     m_done[2];
    int         m_ch  [2];
    longint     m_res [2];
    longint     m_raw [2];
    longint     m_sat [2];
    longint     m_err [2];
    longint     h_res [2];
    longint     h_raw [2];
    longint     h_sat [2];
    longint     h_err [2];
    longint     w_lo  [2][8];
    longint     w_hi  [2][8];
    int         nwin  [2];

    function automatic void chk(string name, longint got, longint expv);
        n_checks++;
        if (got != expv) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, expv);
        end
    endfunction

    // Predict one measurement from the sample delays ns[] (-1 = never rises).
    // e0 is the edge that accepted start.
    task automatic model_txn(input int u, input int alog2, input int ch,
                             input int ns[4], input bit stuck, input longint e0);
        int     s;
        longint t, acc, c, avg, q;
        s = 1 << alog2;
        t = e0;
        acc = 0;
        act[u]  = 1'b1;
        m_e0[u] = e0;
        m_ch[u] = ch;
        nwin[u] = 0;
        m_sat[u] = 0;
        if (stuck) begin
            m_done[u] = e0 + DISCH;
            m_err[u] = 2; m_res[u] = 0; m_raw[u] = 0;
            return;
        end
        for (int i = 0; i < s; i++) begin
            c = (ns[i] < 0) ? 64'd1000000 : longint'(ns[i]) + 2;
            if (c >= TIMEOUT) begin
                w_lo[u][nwin[u]] = t + DISCH;
                w_hi[u][nwin[u]] = t + DISCH + TIMEOUT - 1;
                nwin[u]++;
                m_done[u] = t + DISCH + TIMEOUT;
                m_err[u] = 1; m_res[u] = 255; m_raw[u] = TIMEOUT;
                return;
            end
            w_lo[u][nwin[u]] = t + DISCH;
            w_hi[u][nwin[u]] = t + DISCH + c;
            nwin[u]++;
            t   += DISCH + c + 2;
            acc += c;
        end
        avg = acc / s;
        q   = avg / DIVISOR;
        m_raw[u] = avg;
        m_sat[u] = (q > 255) ? 1 : 0;
        m_res[u] = (q > 255) ? 255 : q;
        m_err[u] = 0;
        m_done[u] = t + CNT_W;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            bit             in_txn, is_done;
            logic [NCH-1:0] exp_ss;
            in_txn  = act[u] && (cyc >= m_e0[u]) && (cyc <= m_done[u]);
            is_done = act[u] && (cyc == m_done[u]);
            exp_ss  = '0;
            if (in_txn)
                for (int i = 0; i < nwin[u]; i++)
                    if (cyc >= w_lo[u][i] && cyc <= w_hi[u][i]) exp_ss[m_ch[u]] = 1'b1;
            if (is_done) begin
                h_res[u] = m_res[u]; h_raw[u] = m_raw[u];
                h_sat[u] = m_sat[u]; h_err[u] = m_err[u];
            end
            chk($sformatf("u%0d_busy", u), longint'(busy[u]), longint'(in_txn));
            chk($sformatf("u%0d_done", u), longint'(done[u]), longint'(is_done));
            chk($sformatf("u%0d_step_set", u), longint'(step_set[u]), longint'(exp_ss));
            chk($sformatf("u%0d_result", u), longint'(result[u]), h_res[u]);
            chk($sformatf("u%0d_raw_count", u), longint'(raw_count[u]), h_raw[u]);
            chk($sformatf("u%0d_sat", u), longint'(sat[u]), h_sat[u]);
            chk($sformatf("u%0d_err", u), longint'(err[u]), h_err[u]);
        end
    end

    // Run one measurement, playing the RC network: step_in rises ns[i]
    // cycles after step_set rises and is released when step_set falls.
    task automatic run_txn(input int u, input int ch, input int ns[4],
                           input bit stuck, input bit poke);
        int     alog2, s, guard;
        longint e0;
        alog2 = (u == 0) ? 0 : 2;
        s = 1 << alog2;
        if (stuck) begin
            step_in[u][ch] = 1'b1;
            repeat (3) @(posedge clk);
            #1;
        end
        start[u]  = 1'b1;
        ch_sel[u] = SEL_W'(ch);
        @(posedge clk); #1;
        start[u] = 1'b0;
        e0 = cyc;
        model_txn(u, alog2, ch, ns, stuck, e0);
        if (poke) begin
            @(posedge clk); #1;
            start[u]  = 1'b1;
            ch_sel[u] = SEL_W'($urandom_range(0, 3));
            @(posedge clk); #1;
            start[u] = 1'b0;
        end
        if (!stuck) begin
            for (int i = 0; i < s; i++) begin
                guard = 0;
                while (!step_set[u][ch] && guard < 64) begin
                    @(posedge clk); #1;
                    guard++;
                end
                if (guard >= 64) begin
                    chk($sformatf("u%0d_charge_start_wait", u), 0, 1);
                    break;
                end
                if (ns[i] < 0) break;
                repeat (ns[i]) @(posedge clk);
                #1;
                step_in[u][ch] = 1'b1;
                guard = 0;
                while (step_set[u][ch] && guard < 5000) begin
                    @(posedge clk); #1;
                    guard++;
                end
                if (guard >= 5000) begin
                    chk($sformatf("u%0d_charge_end_wait", u), 0, 1);
                    break;
                end
                step_in[u][ch] = 1'b0;
            end
        end
        guard = 0;
        while (!done[u] && guard < 6000) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 6000) chk($sformatf("u%0d_done_wait", u), 0, 1);
        $display("txn u%0d ch%0d e0=%0d done=%0d result=%0d raw=%0d sat=%0d err=%0d",
                 u, ch, e0, cyc, result[u], raw_count[u], sat[u], err[u]);
        @(posedge clk); #1;
        step_in[u] = '0;
    endtask

    initial begin
        int ns[4];
        int guard;

        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; ch_sel[u] = '0; step_in[u] = '0;
            act[u] = 1'b0; nwin[u] = 0;
            m_e0[u] = 0; m_done[u] = 0; m_ch[u] = 0;
            h_res[u] = 0; h_raw[u] = 0; h_sat[u] = 0; h_err[u] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", longint'(busy[1]), 0);
        chk("rst_result", longint'(result[0]), 0);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: single sample, N=98 -> count 100 -> result 10
        ns = '{98, -1, -1, -1};
        run_txn(0, 1, ns, 1'b0, 1'b0);
        chk("t1_model_latency", m_done[0] - m_e0[0], 126);
        chk("t1_raw", longint'(raw_count[0]), 100);
        chk("t1_result", longint'(result[0]), 10);
        chk("t1_sat", longint'(sat[0]), 0);
        chk("t1_err", longint'(err[0]), 0);

        // 2: four samples 100,104,100,96 -> mean 100
        ns = '{98, 102, 98, 94};
        run_txn(1, 0, ns, 1'b0, 1'b0);
        chk("t2_model_latency", m_done[1] - m_e0[1], 456);
        chk("t2_raw", longint'(raw_count[1]), 100);
        chk("t2_result", longint'(result[1]), 10);

        // 3: quotient 300 clamps to 255
        ns = '{2998, -1, -1, -1};
        run_txn(0, 3, ns, 1'b0, 1'b0);
        chk("t3_raw", longint'(raw_count[0]), 3000);
        chk("t3_result", longint'(result[0]), 255);
        chk("t3_sat", longint'(sat[0]), 1);
        chk("t3_err", longint'(err[0]), 0);

        // 4: comparator never rises -> timeout
        ns = '{-1, -1, -1, -1};
        run_txn(0, 2, ns, 1'b0, 1'b0);
        chk("t4_model_latency", m_done[0] - m_e0[0], 4008);
        chk("t4_err", longint'(err[0]), 1);
        chk("t4_result", longint'(result[0]), 255);
        chk("t4_raw", longint'(raw_count[0]), 4000);
        chk("t4_step_set", longint'(step_set[0]), 0);

        // 5: comparator stuck high -> error after discharge
        run_txn(0, 3, ns, 1'b1, 1'b1);
        chk("t5_model_latency", m_done[0] - m_e0[0], 8);
        chk("t5_err", longint'(err[0]), 2);
        chk("t5_result", longint'(result[0]), 0);

        // 6: reset in the middle of a charge phase
        ns = '{200, 200, 200, 200};
        start[1] = 1'b1; ch_sel[1] = 3'd1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        model_txn(1, 2, 1, ns, 1'b0, cyc);
        guard = 0;
        while (!step_set[1][1] && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("t6_charge_seen", longint'(step_set[1][1]), 1);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            act[u] = 1'b0;
            h_res[u] = 0; h_raw[u] = 0; h_sat[u] = 0; h_err[u] = 0;
        end
        #1;
        chk("t6_step_set_async", longint'(step_set[1]), 0);
        chk("t6_busy_async", longint'(busy[1]), 0);
        chk("t6_result_async", longint'(result[0]), 0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        @(posedge clk); #1;

        // out-of-range channel is ignored
        start[0] = 1'b1; ch_sel[0] = 3'd5;
        @(posedge clk); #1;
        start[0] = 1'b0;
        @(posedge clk); #1;
        chk("t6_bad_ch_busy", longint'(busy[0]), 0);
        repeat (3) @(posedge clk);
        #1;

        // fresh measurement after reset, with a stray start while busy
        ns = '{50, 60, 70, 80};
        run_txn(1, 1, ns, 1'b0, 1'b1);
        chk("t6_after_reset_raw", longint'(raw_count[1]), 67);
        chk("t6_after_reset_result", longint'(result[1]), 6);

        // randomized measurements on both instances
        for (int k = 0; k < 10; k++) begin
            int u, ch;
            bit stuck, poke;
            u = k % 2;
            ch = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) ns[i] = $urandom_range(0, 300);
            stuck = ($urandom_range(0, 9) == 0);
            poke  = $urandom_range(0, 1) == 1;
            run_txn(u, ch, ns, stuck, poke);
            repeat ($urandom_range(0, 4)) @(posedge clk);
            #1;
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop in case a wait misbehaves
    initial begin
        #900000;
        $display("FAIL watchdog at cycle %0d: got no finish, expected finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
